// File: rtl/uart_waveform_rx.sv
// Receive side of the ADC waveform serial link: 8N1 deserializer, 3-byte record
// assembly into 14-bit samples, and a 32-entry shadow/published waveform buffer.
module uart_waveform_rx #(
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter int unsigned IDLE_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              uart_in,
    output logic [31:0][13:0] waveform,
    output logic              wave_valid,
    output logic [7:0]        rx_byte,
    output logic              rx_byte_valid,
    output logic              framing_err,
    output logic              seq_err,
    output logic [5:0]        record_count
);

    localparam int unsigned   HALF   = (CLKS_PER_BIT - 1) / 2;
    localparam int unsigned   CW     = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned   TW     = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [CW-1:0] HALF_C = CW'(HALF);
    localparam logic [CW-1:0] LAST_C = CW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TOUT_C = TW'(IDLE_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state_q, state_d;
    logic [1:0]        sync_q;
    logic              rxs;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              stop_ok, stop_bad;

    logic [1:0]        bidx_q, bidx_d;
    logic [5:0]        hi_q, hi_d;
    logic [7:0]        lo_q, lo_d;
    logic              clean_q, clean_d;
    logic [5:0]        exp_q, exp_d;
    logic [5:0]        rc_q, rc_d;
    logic [TW-1:0]     idle_q, idle_d;
    logic [31:0][13:0] shadow_q, shadow_d;
    logic [31:0][13:0] wave_q;
    logic              publish;
    logic              seq_ok;
    logic [7:0]        rxb_q, rxb_d;
    logic              rbv_q, rbv_d;
    logic              ferr_q, ferr_d;
    logic              serr_q, serr_d;
    logic              wv_q, wv_d;

    assign rxs = sync_q[1];

    // Bit-level FSM; with HALF==0 the start bit is confirmed in IDLE itself.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rxs) begin
                    bit_d = '0;
                    if (HALF_C == '0) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end else begin
                        state_d = START;
                        cnt_d   = CW'(1);
                    end
                end
            end
            START: begin
                if (cnt_q == HALF_C) begin
                    cnt_d   = '0;
                    state_d = rxs ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == LAST_C) begin
                    cnt_d   = '0;
                    shift_d = {rxs, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == LAST_C) begin
                    cnt_d    = '0;
                    state_d  = IDLE;
                    stop_ok  = rxs;
                    stop_bad = !rxs;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bidx_d   = bidx_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        clean_d  = clean_q;
        exp_d    = exp_q;
        rc_d     = rc_q;
        idle_d   = '0;
        shadow_d = shadow_q;
        publish  = 1'b0;
        seq_ok   = 1'b0;
        rxb_d    = rxb_q;
        rbv_d    = 1'b0;
        ferr_d   = 1'b0;
        serr_d   = 1'b0;
        wv_d     = 1'b0;

        if (state_q == IDLE && rxs && bidx_q != 2'd0) begin
            if (idle_q == TOUT_C) bidx_d = 2'd0;
            else                  idle_d = idle_q + 1'b1;
        end

        if (stop_bad) begin
            ferr_d  = 1'b1;
            bidx_d  = 2'd0;
            clean_d = 1'b0;
        end

        if (stop_ok) begin
            rbv_d = 1'b1;
            rxb_d = shift_q;
            case (bidx_q)
                2'd0: begin
                    hi_d   = shift_q[5:0];
                    bidx_d = 2'd1;
                end
                2'd1: begin
                    lo_d   = shift_q;
                    bidx_d = 2'd2;
                end
                default: begin
                    bidx_d = 2'd0;
                    if (shift_q >= 8'd32) begin
                        serr_d  = 1'b1;
                        clean_d = 1'b0;
                    end else begin
                        shadow_d[shift_q[4:0]] = {hi_q, lo_q};
                        if (shift_q == 8'd0) begin
                            clean_d = 1'b1;
                            rc_d    = 6'd1;
                            exp_d   = 6'd1;
                        end else begin
                            seq_ok = (shift_q[5:0] == exp_q);
                            if (!seq_ok) begin
                                serr_d  = 1'b1;
                                clean_d = 1'b0;
                            end
                            exp_d = shift_q[5:0] + 6'd1;
                            if (rc_q != 6'd32) rc_d = rc_q + 6'd1;
                            // Publish from shadow_d so the index-31 entry lands in the same cycle.
                            if (shift_q[4:0] == 5'd31 && clean_q && seq_ok) begin
                                publish = 1'b1;
                                wv_d    = 1'b1;
                                clean_d = 1'b0;
                            end
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= '1;
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            bidx_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            clean_q  <= 1'b0;
            exp_q    <= '0;
            rc_q     <= '0;
            idle_q   <= '0;
            shadow_q <= '0;
            wave_q   <= '0;
            rxb_q    <= '0;
            rbv_q    <= 1'b0;
            ferr_q   <= 1'b0;
            serr_q   <= 1'b0;
            wv_q     <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], uart_in};
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            bidx_q   <= bidx_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            clean_q  <= clean_d;
            exp_q    <= exp_d;
            rc_q     <= rc_d;
            idle_q   <= idle_d;
            shadow_q <= shadow_d;
            if (publish) wave_q <= shadow_d;
            rxb_q    <= rxb_d;
            rbv_q    <= rbv_d;
            ferr_q   <= ferr_d;
            serr_q   <= serr_d;
            wv_q     <= wv_d;
        end
    end

    assign waveform      = wave_q;
    assign wave_valid    = wv_q;
    assign rx_byte       = rxb_q;
    assign rx_byte_valid = rbv_q;
    assign framing_err   = ferr_q;
    assign seq_err       = serr_q;
    assign record_count  = rc_q;

endmodule

// File: tb/tb_uart_waveform_rx.sv
// Bench for uart_waveform_rx: byte-level reference model feeding a timed scoreboard,
// a table of record vectors, and directed framing/timeout/reset/false-start sequences.
module tb_uart_waveform_rx;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic uart1 = 1'b1;
    logic uart16 = 1'b1;

    logic [31:0][13:0] waveform, waveform16;
    logic wave_valid, rx_byte_valid, framing_err, seq_err;
    logic wave_valid16, rx_byte_valid16, framing_err16, seq_err16;
    logic [7:0] rx_byte, rx_byte16;
    logic [5:0] record_count, record_count16;

    uart_waveform_rx #(.CLKS_PER_BIT(1), .IDLE_TIMEOUT(64)) dut (
        .clk(clk), .reset(reset), .uart_in(uart1), .waveform(waveform),
        .wave_valid(wave_valid), .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid),
        .framing_err(framing_err), .seq_err(seq_err), .record_count(record_count)
    );

    uart_waveform_rx #(.CLKS_PER_BIT(16), .IDLE_TIMEOUT(64)) dut16 (
        .clk(clk), .reset(reset), .uart_in(uart16), .waveform(waveform16),
        .wave_valid(wave_valid16), .rx_byte(rx_byte16), .rx_byte_valid(rx_byte_valid16),
        .framing_err(framing_err16), .seq_err(seq_err16), .record_count(record_count16)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    logic rst_prev = 1'b1;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_prev <= reset;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [447:0] act, input logic [447:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        int                cyc;
        logic [7:0]        rx;
        logic              rbv, ferr, serr, wv;
        logic [5:0]        cnt;
        logic [31:0][13:0] wave;
    } ev_t;

    ev_t sb[$];
    int m_bidx, m_exp, m_cnt, last_stop;
    bit m_clean;
    logic [5:0] m_hi;
    logic [7:0] m_lo, m_rx;
    logic [31:0][13:0] m_shadow, m_wave;

    task automatic model_reset();
        m_bidx = 0; m_exp = 0; m_cnt = 0; m_clean = 0;
        m_hi = '0; m_lo = '0; m_rx = '0;
        m_shadow = '0; m_wave = '0;
        sb.delete();
        last_stop = cyc;
    endtask

    task automatic model_byte(input logic [7:0] d, input bit good, input int s, input int gap);
        ev_t e;
        int idx;
        if (gap >= 64 && m_bidx != 0) m_bidx = 0;
        e.cyc = s + 3; e.rbv = good; e.ferr = !good; e.serr = 0; e.wv = 0;
        if (!good) begin
            m_bidx = 0; m_clean = 0;
        end else begin
            m_rx = d;
            if (m_bidx == 0) begin
                m_hi = d[5:0]; m_bidx = 1;
            end else if (m_bidx == 1) begin
                m_lo = d; m_bidx = 2;
            end else begin
                m_bidx = 0;
                idx = int'(d);
                if (idx > 31) begin
                    e.serr = 1; m_clean = 0;
                end else begin
                    m_shadow[idx] = {m_hi, m_lo};
                    if (idx == 0) begin
                        m_clean = 1; m_cnt = 1; m_exp = 1;
                    end else begin
                        if (idx != m_exp) begin e.serr = 1; m_clean = 0; end
                        m_exp = idx + 1;
                        m_cnt = (m_cnt < 32) ? m_cnt + 1 : 32;
                        if (idx == 31 && m_clean) begin
                            m_wave = m_shadow; e.wv = 1; m_clean = 0;
                        end
                    end
                end
            end
        end
        e.rx = m_rx; e.cnt = 6'(m_cnt); e.wave = m_wave;
        sb.push_back(e);
    endtask

    // ---------------- monitor (mid-cycle sampling) ----------------
    bit mon_en = 0;
    int n_rbv = 0, n_ferr = 0, n_serr = 0, n_wv = 0;
    bit last_serr = 0;
    ev_t mon_ev;
    logic [31:0][13:0] prev_wave = '0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (rx_byte_valid) n_rbv++;
            if (framing_err)   n_ferr++;
            if (seq_err)       n_serr++;
            if (wave_valid)    n_wv++;
            if (rx_byte_valid || framing_err) last_serr = seq_err;
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                mon_ev = sb.pop_front();
                checks++; errors++;
                $display("FAIL ev_timing: no pulse at cycle %0d, required rbv=%0b ferr=%0b", mon_ev.cyc, mon_ev.rbv, mon_ev.ferr);
            end
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                mon_ev = sb.pop_front();
                chk("ev_rbv", rx_byte_valid, mon_ev.rbv);
                chk("ev_ferr", framing_err, mon_ev.ferr);
                chk("ev_serr", seq_err, mon_ev.serr);
                chk("ev_wv", wave_valid, mon_ev.wv);
                chk("ev_rx_byte", rx_byte, mon_ev.rx);
                chk("ev_count", record_count, mon_ev.cnt);
                chk("ev_wave", waveform, mon_ev.wave);
            end else if (rx_byte_valid || framing_err || seq_err || wave_valid) begin
                checks++; errors++;
                $display("FAIL ev_spurious: pulses rbv=%0b ferr=%0b serr=%0b wv=%0b at cycle %0d, required none",
                         rx_byte_valid, framing_err, seq_err, wave_valid, cyc);
            end
            if (!rst_prev && !wave_valid) chk("wave_hold", waveform, prev_wave);
            prev_wave = waveform;
        end
    end

    int n16_rbv = 0, n16_err = 0, c16_rbv = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (rx_byte_valid16) begin n16_rbv++; c16_rbv = cyc; end
            if (framing_err16 || seq_err16 || wave_valid16) n16_err++;
        end
    end

    // ---------------- drivers ----------------
    task automatic line(input logic b);
        uart1 = b;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) line(1'b1);
    endtask

    task automatic send_byte(input logic [7:0] d, input bit good);
        int gap, s;
        gap = cyc - last_stop - 1;
        line(1'b0);
        for (int i = 0; i < 8; i++) line(d[i]);
        s = cyc;
        line(good);
        last_stop = s;
        model_byte(d, good, s, gap);
    endtask

    task automatic send_record(input logic [13:0] smp, input logic [7:0] idx, input bit bad_lo);
        logic [1:0] junk;
        junk = 2'($urandom_range(0, 3));
        send_byte({junk, smp[13:8]}, 1'b1);
        send_byte(smp[7:0], !bad_lo);
        send_byte(idx, 1'b1);
    endtask

    function automatic logic [13:0] samp(input int i, input int k);
        return 14'((i * k) % 16384);
    endfunction

    function automatic logic [31:0][13:0] wave_of(input int k);
        logic [31:0][13:0] w;
        for (int i = 0; i < 32; i++) w[i] = samp(i, k);
        return w;
    endfunction

    task automatic send_wave(input int k, input int bad_rec);
        for (int i = 0; i < 32; i++) send_record(samp(i, k), 8'(i), i == bad_rec);
    endtask

    task automatic line16(input logic b, input int n);
        uart16 = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [13:0] smp;
        logic [7:0]  idx;
        logic        exp_seq;
        logic [5:0]  exp_cnt;
    } row_t;
    row_t rows[7];

    int r0, f0, s0, w0, u0, b16, e16;
    logic [31:0][13:0] held;

    initial begin
        rows[0] = '{14'h1234, 8'd0,    1'b0, 6'd1};
        rows[1] = '{14'h0ABC, 8'd1,    1'b0, 6'd2};
        rows[2] = '{14'h3FFF, 8'd3,    1'b1, 6'd3};
        rows[3] = '{14'h0001, 8'h40,   1'b1, 6'd3};
        rows[4] = '{14'h2222, 8'd4,    1'b0, 6'd4};
        rows[5] = '{14'h1111, 8'd31,   1'b1, 6'd5};
        rows[6] = '{14'h0555, 8'd0,    1'b0, 6'd1};

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        mon_en = 1;
        chk("rst_wave_valid", wave_valid, 1'b0);
        chk("rst_rbv", rx_byte_valid, 1'b0);
        chk("rst_ferr", framing_err, 1'b0);
        chk("rst_serr", seq_err, 1'b0);
        chk("rst_rx_byte", rx_byte, 8'h00);
        chk("rst_count", record_count, 6'd0);
        chk("rst_waveform", waveform, '0);
        idle(5);

        // Nominal back-to-back waveform
        r0 = n_rbv; f0 = n_ferr; s0 = n_serr; w0 = n_wv;
        send_wave(517, -1);
        idle(6);
        chk("nom_rbv_count", n_rbv - r0, 96);
        chk("nom_wv_count", n_wv - w0, 1);
        chk("nom_ferr_count", n_ferr - f0, 0);
        chk("nom_serr_count", n_serr - s0, 0);
        chk("nom_record_count", record_count, 6'd32);
        for (int i = 0; i < 32; i++) chk($sformatf("nom_w%0d", i), waveform[i], samp(i, 517));

        // Record vectors
        for (int r = 0; r < 7; r++) begin
            send_record(rows[r].smp, rows[r].idx, 1'b0);
            idle(4);
            chk($sformatf("tbl%0d_seq", r), last_serr, rows[r].exp_seq);
            chk($sformatf("tbl%0d_count", r), record_count, rows[r].exp_cnt);
        end
        chk("tbl_waveform_held", waveform, wave_of(517));
        idle(70);

        // Framing error on byte 1 of record 5
        f0 = n_ferr; s0 = n_serr; w0 = n_wv;
        send_wave(1021, 5);
        idle(70);
        chk("fr_ferr_count", n_ferr - f0, 1);
        chk("fr_serr_seen", (n_serr - s0) > 0, 1'b1);
        chk("fr_wv_count", n_wv - w0, 0);
        chk("fr_waveform_held", waveform, wave_of(517));
        w0 = n_wv;
        send_wave(1021, -1);
        idle(6);
        chk("fr_recover_wv", n_wv - w0, 1);
        chk("fr_recover_wave", waveform, wave_of(1021));

        // Idle timeout: 64 idle cycles abandon the partial record
        s0 = n_serr; w0 = n_wv;
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        idle(64);
        send_wave(77, -1);
        idle(6);
        chk("to64_serr", n_serr - s0, 0);
        chk("to64_wv", n_wv - w0, 1);
        chk("to64_wave", waveform, wave_of(77));
        // 63 idle cycles: next byte completes the stale record as its index
        s0 = n_serr;
        send_byte(8'h05, 1'b1);
        send_byte(8'h06, 1'b1);
        idle(63);
        send_byte(8'h07, 1'b1);
        idle(6);
        chk("to63_serr", n_serr - s0, 1);
        chk("to63_count", record_count, 6'd32);
        idle(70);

        // Reset mid-DATA of record 10
        for (int i = 0; i < 10; i++) send_record(samp(i, 301), 8'(i), 1'b0);
        send_byte(8'h01, 1'b1);
        line(1'b0);
        line(1'b1); line(1'b0); line(1'b1); line(1'b1);
        uart1 = 1'b1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        chk("mid_rst_wave_valid", wave_valid, 1'b0);
        chk("mid_rst_rbv", rx_byte_valid, 1'b0);
        chk("mid_rst_ferr", framing_err, 1'b0);
        chk("mid_rst_serr", seq_err, 1'b0);
        chk("mid_rst_rx_byte", rx_byte, 8'h00);
        chk("mid_rst_count", record_count, 6'd0);
        chk("mid_rst_waveform", waveform, '0);
        idle(20);
        w0 = n_wv;
        send_wave(2003, -1);
        idle(6);
        chk("post_rst_wv", n_wv - w0, 1);
        chk("post_rst_wave", waveform, wave_of(2003));

        // CLKS_PER_BIT=16: false start then a real byte
        b16 = n16_rbv; e16 = n16_err;
        line16(1'b0, 3);
        line16(1'b1, 200);
        chk("fs_no_byte", n16_rbv - b16, 0);
        chk("fs_no_err", n16_err - e16, 0);
        u0 = cyc;
        line16(1'b0, 16);
        for (int i = 0; i < 8; i++) line16(held[0][0] | (8'hA5 >> i) & 8'h01 ? 1'b1 : 1'b0, 16);
        line16(1'b1, 40);
        chk("a5_count", n16_rbv - b16, 1);
        chk("a5_byte", rx_byte16, 8'hA5);
        chk("a5_cycle", c16_rbv, u0 + 154);
        chk("a5_no_err", n16_err - e16, 0);

        repeat (10) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial held = '0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_waveform_rx.md
# uart_waveform_rx

Receive side of the ADC waveform serial link. Deserializes the 8N1 bitstream produced by the waveform transmitter, reassembles each 3-byte record (sample high bits, sample low bits, sample index) into a 14-bit ADC sample, and fills a 32-entry waveform buffer. A complete, error-free waveform is published on a held output array with a one-cycle valid pulse. Used for FPGA-side loopback verification and for board-to-board waveform transfer.

## Interface
- CLKS_PER_BIT, 1, clock cycles per serial bit (≥1); 1 matches the transmitter's one-bit-per-clock output.
- IDLE_TIMEOUT, 64, consecutive idle-high cycles that abandon a partial record.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- uart_in  in  1  serial line, idle high.
- waveform  out  [13:0] x32  last complete waveform, held until the next complete waveform.
- wave_valid  out  1  one-cycle pulse when waveform updates.
- rx_byte  out  8  last received byte (debug).
- rx_byte_valid  out  1  one-cycle pulse per byte with a good stop bit.
- framing_err  out  1  one-cycle pulse on stop bit = 0.
- seq_err  out  1  one-cycle pulse on index out of order or ≥32.
- record_count  out  6  records accepted since last index-0 record (0..32).

## Operation
- uart_in passes through a 2-flop synchronizer (reset to 1); all logic uses the synchronized bit `rxs`.
- Bit FSM states: IDLE, START, DATA, STOP.
  - IDLE: `rxs`=0 at cycle t0 → START. HALF = (CLKS_PER_BIT-1)/2, integer division.
  - START: at t0+HALF, `rxs`=0 → DATA; `rxs`=1 → IDLE (false start, no outputs). With CLKS_PER_BIT=1 this check happens at t0.
  - DATA: bit k (k=0..7, LSB first) sampled at t0+HALF+(k+1)·CLKS_PER_BIT.
  - STOP: sampled at t0+HALF+9·CLKS_PER_BIT. 1 → rx_byte_valid; 0 → framing_err. Either way → IDLE next cycle, so back-to-back frames at CLKS_PER_BIT=1 are received without gaps.
- Record assembly uses byte_idx, 0..2:
  - Byte 0: bits [5:0] → sample[13:8]. Bits [7:6] are ignored (don't-care from the transmitter).
  - Byte 1: → sample[7:0].
  - Byte 2: index.
- Framing error: the partial record is discarded, byte_idx←0, and clean←0.
- Idle timeout: with byte_idx≠0, `rxs`=1 in IDLE for IDLE_TIMEOUT consecutive cycles → byte_idx←0 and the partial record is discarded. No error pulse.
- Record commit happens on the byte-2 stop bit:
  - index ≥32: seq_err, nothing written, clean←0.
  - Otherwise, shadow[index]←sample.
  - index==0: clean←1, record_count←1, expected←1.
  - index≠0: if index≠expected, seq_err and clean←0. Then expected←index+1 and record_count←record_count+1, saturating at 32.
  - index==31 with clean=1 after the checks: waveform←shadow, including the entry written in the same cycle. wave_valid pulses, then clean←0.
- Reset clears:
  - All FSM, counters and flags; clean=0, expected=0.
  - Shadow buffer and waveform all zeros.
  - All pulse outputs 0, rx_byte=0, record_count=0.
  - A reset mid-byte or mid-record drops everything received so far.

## Timing
- Let s be the cycle in which the stop bit's sample point lands on uart_in (pre-synchronizer).
  - rx_byte_valid, framing_err, seq_err and wave_valid assert at s+3: 2 cycles of synchronizer plus 1 registered output.
  - waveform and record_count update in that same cycle.
- With CLKS_PER_BIT=1, a full 32-record waveform is 960 line cycles. wave_valid comes 3 cycles after the final stop bit.
- Pulses last exactly one cycle; simultaneous pulses (e.g. rx_byte_valid with seq_err) are allowed.
- waveform never changes except on the wave_valid cycle or reset.

## Test plan
- Nominal: transmitter-format stream at CLKS_PER_BIT=1, sample[i] = (i·517) mod 16384, indices 0..31 back-to-back → exactly one wave_valid, waveform[i] matches every entry, 96 rx_byte_valid pulses, no error pulses, record_count=32.
- Framing: stop bit of byte 1 of record 5 forced to 0 → framing_err once, then seq_err at record 6, no wave_valid. A following clean waveform → wave_valid, previous waveform output unchanged until then.
- False start: CLKS_PER_BIT=16, 3-cycle low glitch on idle line → no rx_byte_valid and no errors. Then byte 0xA5 → rx_byte=0xA5.
- Timeout: two bytes, then 64 idle cycles, then a full waveform → wave_valid with correct data and no seq_err. With 63 idle cycles instead, the next byte is treated as byte 2 (index) of the stale record.
- Bad index: record with byte 2 = 0x40 → seq_err, shadow unchanged. Record-out-of-order (3 after 1) → seq_err, no wave_valid for that waveform.
- Reset: reset asserted for 1 cycle mid-DATA of record 10 → all outputs at reset values the next cycle. A subsequent full waveform → wave_valid and correct data.
